// File: rtl/leap_count_accumulator.sv
// Per-function accumulator for LEAP increment counts, with a clear-on-read streaming dump port.
// Optional LEAP_ACC_SATURATE_EN: overflowing bins saturate to all ones instead of wrapping.
module leap_count_accumulator #(
  parameter int unsigned CW    = 32,
  parameter int unsigned N2    = 8,
  parameter int unsigned ACC_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CW-1:0]    count,
  input  logic             event_valid,
  input  logic [N2-1:0]    func_idx,
  input  logic             dump_start,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [N2-1:0]    dump_idx,
  output logic [ACC_W-1:0] dump_data,
  output logic             dump_done,
  output logic             busy,
  output logic             acc_overflow,
  output logic             event_dropped
);

  localparam int unsigned   NB      = 2 ** N2;
  localparam logic [N2-1:0] LastIdx = N2'(NB - 1);

  typedef enum logic [1:0] {StClear, StIdle, StDrain, StDump} state_e;

  state_e state_q, state_d;

  logic [N2-1:0]    ptr_q, ptr_d;
  logic             acc_valid_q;
  logic [N2-1:0]    acc_idx_q;
  logic [CW-1:0]    acc_cnt_q;
  logic             fwd_q;
  logic [ACC_W-1:0] fwd_data_q;
  logic [ACC_W-1:0] rd_q;
  logic             dump_valid_q, dump_valid_d;
  logic [N2-1:0]    dump_idx_q, dump_idx_d;
  logic             dump_done_q, dump_done_d;
  logic             overflow_q, dropped_q;

  logic [ACC_W-1:0] mem [NB];

  logic             accept;
  logic             fwd_hit;
  logic             carry;
  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] acc_operand;
  logic [ACC_W-1:0] acc_result;
  logic             rd_en;
  logic [N2-1:0]    rd_addr;
  logic             wr_en;
  logic [N2-1:0]    wr_addr;
  logic [ACC_W-1:0] wr_data;

  assign accept      = event_valid && (state_q == StIdle);
  // The RAM read issued alongside a write to the same bin returns stale data; use the sum instead.
  assign fwd_hit     = accept && acc_valid_q && (acc_idx_q == func_idx);
  assign acc_operand = fwd_q ? fwd_data_q : rd_q;
  assign sum_full    = {1'b0, acc_operand} + {{(ACC_W + 1 - CW){1'b0}}, acc_cnt_q};
  assign carry       = sum_full[ACC_W];

`ifdef LEAP_ACC_SATURATE_EN
  assign acc_result = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
  assign acc_result = sum_full[ACC_W-1:0];
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    dump_done_d  = 1'b0;
    rd_en        = accept;
    rd_addr      = func_idx;
    wr_en        = acc_valid_q;
    wr_addr      = acc_idx_q;
    wr_data      = acc_result;

    unique case (state_q)
      StClear: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = '0;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (dump_start) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!acc_valid_q) begin
          state_d = StDump;
        end
      end
      StDump: begin
        if (!dump_valid_q) begin
          // First beat: fetch bin 0; the RAM output register then serves as the data holder.
          rd_en        = 1'b1;
          rd_addr      = dump_idx_q;
          dump_valid_d = 1'b1;
        end else if (dump_ready) begin
          wr_en   = 1'b1;
          wr_addr = dump_idx_q;
          wr_data = '0;
          if (dump_idx_q == LastIdx) begin
            dump_valid_d = 1'b0;
            dump_idx_d   = '0;
            dump_done_d  = 1'b1;
            state_d      = StIdle;
          end else begin
            rd_en      = 1'b1;
            rd_addr    = dump_idx_q + 1'b1;
            dump_idx_d = dump_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StClear;
      ptr_q        <= '0;
      acc_valid_q  <= 1'b0;
      acc_idx_q    <= '0;
      acc_cnt_q    <= '0;
      fwd_q        <= 1'b0;
      fwd_data_q   <= '0;
      rd_q         <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_done_q  <= dump_done_d;
      acc_valid_q  <= accept;
      if (accept) begin
        acc_idx_q  <= func_idx;
        acc_cnt_q  <= count;
        fwd_q      <= fwd_hit;
        fwd_data_q <= acc_result;
      end
      if (rd_en) begin
        rd_q <= mem[rd_addr];
      end
      if (acc_valid_q && carry) begin
        overflow_q <= 1'b1;
      end
      if (event_valid && !accept) begin
        dropped_q <= 1'b1;
      end
    end
  end

  assign dump_valid    = dump_valid_q;
  assign dump_idx      = dump_idx_q;
  assign dump_data     = dump_valid_q ? rd_q : '0;
  assign dump_done     = dump_done_q;
  assign busy          = (state_q != StIdle) && !reset;
  assign acc_overflow  = overflow_q;
  assign event_dropped = dropped_q;

endmodule

// File: tb/tb_leap_count_accumulator.sv
// Randomized bench for leap_count_accumulator against a bin-array reference model.
module tb_leap_count_accumulator;

  localparam int unsigned CW    = 32;
  localparam int unsigned N2    = 8;
  localparam int unsigned ACC_W = 48;
  localparam int unsigned NB    = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [CW-1:0]    count;
  logic             event_valid;
  logic [N2-1:0]    func_idx;
  logic             dump_start;
  logic             dump_ready;
  logic             dump_valid;
  logic [N2-1:0]    dump_idx;
  logic [ACC_W-1:0] dump_data;
  logic             dump_done;
  logic             busy;
  logic             acc_overflow;
  logic             event_dropped;

  logic          e32_valid;
  logic [N2-1:0] e32_idx;
  logic [31:0]   e32_count;
  logic          e32_start;
  logic          e32_ready;
  logic          d32_valid;
  logic [N2-1:0] d32_idx;
  logic [31:0]   d32_data;
  logic          d32_done;
  logic          d32_busy;
  logic          d32_ovf;
  logic          d32_dropped;

  leap_count_accumulator #(.CW(CW), .N2(N2), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .count(count), .event_valid(event_valid), .func_idx(func_idx),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done), .busy(busy),
    .acc_overflow(acc_overflow), .event_dropped(event_dropped)
  );

  leap_count_accumulator #(.CW(32), .N2(N2), .ACC_W(32)) dut32 (
    .clk(clk), .reset(reset), .count(e32_count), .event_valid(e32_valid), .func_idx(e32_idx),
    .dump_start(e32_start), .dump_ready(e32_ready), .dump_valid(d32_valid),
    .dump_idx(d32_idx), .dump_data(d32_data), .dump_done(d32_done), .busy(d32_busy),
    .acc_overflow(d32_ovf), .event_dropped(d32_dropped)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [ACC_W-1:0] m_bin [NB];
  logic [ACC_W-1:0] cap [NB];
  logic [31:0]      cap32 [NB];
  int clear_left = 0;
  bit in_dump = 0;
  int exp_idx = 0;
  bit done_pend = 0;
  bit m_ovf = 0;
  bit m_dropped = 0;
  int quiet = 2;
  int beats_total = 0;
  int dones = 0;
  int d32_dones = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [ACC_W:0] s;
    bit busy_exp;
    if (reset) begin
      chk("reset flags", 64'({dump_valid, dump_done, busy, acc_overflow, event_dropped, dump_idx}),
          64'd0);
      chk("reset dump_data", 64'(dump_data), 64'd0);
      for (int i = 0; i < NB; i++) m_bin[i] = '0;
      clear_left = NB;
      in_dump    = 0;
      exp_idx    = 0;
      done_pend  = 0;
      m_ovf      = 0;
      m_dropped  = 0;
      quiet      = 2;
    end else begin
      busy_exp = (clear_left != 0) || in_dump;
      chk("busy", 64'(busy), 64'(busy_exp));
      chk("dump_done", 64'(dump_done), 64'(done_pend));
      chk("event_dropped", 64'(event_dropped), 64'(m_dropped));
      if (quiet >= 2) chk("acc_overflow", 64'(acc_overflow), 64'(m_ovf));
      if (dump_done) dones++;
      done_pend = 0;
      if (dump_valid) begin
        if (!in_dump) begin
          chk("dump_valid outside dump", 64'(dump_valid), 64'd0);
        end else begin
          chk("dump_idx", 64'(dump_idx), 64'(exp_idx));
          chk("dump_data", 64'(dump_data), 64'(m_bin[exp_idx]));
          if (dump_ready) begin
            cap[exp_idx]   = dump_data;
            m_bin[exp_idx] = '0;
            beats_total++;
            if (exp_idx == NB - 1) begin
              in_dump   = 0;
              done_pend = 1;
              exp_idx   = 0;
            end else begin
              exp_idx++;
            end
          end
        end
      end
      quiet = (quiet < 2) ? quiet + 1 : 2;
      if (event_valid) begin
        if (busy_exp) begin
          m_dropped = 1;
        end else begin
          s = {1'b0, m_bin[func_idx]} + (ACC_W + 1)'(count);
          if (s[ACC_W]) begin
            m_ovf = 1;
`ifdef LEAP_ACC_SATURATE_EN
            m_bin[func_idx] = '1;
`else
            m_bin[func_idx] = s[ACC_W-1:0];
`endif
          end else begin
            m_bin[func_idx] = s[ACC_W-1:0];
          end
          quiet = 0;
        end
      end
      if (dump_start && !busy_exp) begin
        in_dump = 1;
        exp_idx = 0;
      end
      if (clear_left != 0) clear_left--;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (d32_valid && e32_ready) cap32[d32_idx] = d32_data;
      if (d32_done) d32_dones++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input int idx, input logic [31:0] cnt);
    event_valid = 1'b1;
    func_idx    = N2'(idx);
    count       = cnt;
    tick();
    event_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 1000 && (clear_left != 0 || in_dump); c++) tick();
    chk("idle reached", 64'(busy), 64'd0);
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic do_dump(input int mode, input bit noisy, output int nbeats);
    int d0;
    int b0;
    int ph;
    wait_idle();
    d0 = dones;
    b0 = beats_total;
    ph = 0;
    dump_start  = 1'b1;
    event_valid = noisy && ($urandom_range(0, 1) == 1);
    func_idx    = N2'($urandom_range(0, 3));
    count       = $urandom;
    tick();
    dump_start = 1'b0;
    for (int c = 0; c < 3000 && dones == d0; c++) begin
      case (mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: dump_ready = ($urandom_range(0, 1) == 1);
      endcase
      ph++;
      event_valid = noisy && in_dump && ($urandom_range(0, 3) == 0);
      func_idx    = N2'($urandom_range(0, NB - 1));
      count       = $urandom;
      tick();
    end
    dump_ready  = 1'b0;
    event_valid = 1'b0;
    chk("dump_done within bound", 64'(dones - d0), 64'd1);
    nbeats = beats_total - b0;
  endtask

  initial begin
    int b;
    logic [ACC_W-1:0] acc_or;
    logic [31:0] exp32;
    reset = 1'b1; event_valid = 1'b0; count = '0; func_idx = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    e32_valid = 1'b0; e32_idx = '0; e32_count = '0; e32_start = 1'b0; e32_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    // Reset again in the middle of CLEAR
    repeat (100) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    wait_idle();
    chk("event_dropped clean", 64'(event_dropped), 64'd0);

    do_dump(0, 0, b);
    chk("beats after clear", 64'(b), 64'd256);
    chk("bin 200 after clear", 64'(cap[200]), 64'd0);

    ev(3, 32'd10);
    ev(3, 32'd5);
    tick();
    do_dump(0, 0, b);
    chk("bin 3 forwarded", 64'(cap[3]), 64'd15);
    chk("bin 2 untouched", 64'(cap[2]), 64'd0);

    ev(7, 32'hFFFF_FFFF);
    tick();
    ev(7, 32'hFFFF_FFFF);
    tick(); tick();
    ev(7, 32'hFFFF_FFFF);
    repeat (3) tick();
    chk("overflow after 3x max", 64'(acc_overflow), 64'd0);
    do_dump(0, 0, b);
    chk("bin 7 three max", 64'(cap[7]), 64'h2_FFFF_FFFD);

    for (int i = 0; i < 20; i++) ev((i * 13) % NB, 32'(i + 1));
    tick();
    do_dump(1, 1, b);
    chk("beats with stalls", 64'(b), 64'd256);
    chk("bin 26 stalled dump", 64'(cap[26]), 64'd3);
    chk("event_dropped during dump", 64'(event_dropped), 64'd1);
    do_dump(0, 0, b);
    acc_or = '0;
    for (int i = 0; i < NB; i++) acc_or |= cap[i];
    chk("second dump all zero", 64'(acc_or), 64'd0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (50) tick();
    ev(9, 32'd77);
    wait_idle();
    chk("event_dropped during clear", 64'(event_dropped), 64'd1);
    do_dump(2, 0, b);
    chk("bin 9 after dropped event", 64'(cap[9]), 64'd0);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 80; c++) begin
        event_valid = ($urandom_range(0, 9) < 6);
        func_idx    = ($urandom_range(0, 1) == 1) ? N2'($urandom_range(0, 3))
                                                   : N2'($urandom_range(0, NB - 1));
        count       = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        tick();
      end
      do_dump(r % 3, 1, b);
      chk("random round beats", 64'(b), 64'd256);
    end

    e32_valid = 1'b1; e32_idx = N2'(1); e32_count = 32'hFFFF_FFF0;
    tick();
    e32_valid = 1'b0;
    repeat (3) tick();
    chk("acc32 overflow before", 64'(d32_ovf), 64'd0);
    e32_valid = 1'b1; e32_count = 32'h20;
    tick();
    e32_valid = 1'b0;
    repeat (3) tick();
    chk("acc32 overflow after", 64'(d32_ovf), 64'd1);
    e32_start = 1'b1; e32_ready = 1'b1;
    tick();
    e32_start = 1'b0;
    for (int c = 0; c < 600 && d32_dones == 0; c++) tick();
    chk("acc32 dump done", 64'(d32_dones), 64'd1);
`ifdef LEAP_ACC_SATURATE_EN
    exp32 = 32'hFFFF_FFFF;
`else
    exp32 = 32'h10;
`endif
    chk("acc32 bin 1", 64'(cap32[1]), 64'(exp32));
    chk("acc32 bin 0", 64'(cap32[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/leap_count_accumulator.md
Name: leap_count_accumulator

Overview:
- Downstream consumer of the LEAP per-function increment counter.
- On every call or return event, it samples the counter's current value and the index of the function being left. It then adds that value into a per-function accumulator bin held in on-chip synchronous RAM.
- A handshake dump port streams all bins out to the host-side readout logic, clearing each bin as it is read.

Parameters:
- CW, 32, width of incoming count.
- N2, 8, log2 of number of bins; NB = 2**N2.
- ACC_W, 48, accumulator bin width; must be >= CW.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- count  in  CW  increment-counter value, valid in the event cycle
- event_valid  in  1  call or return event this cycle (call_as_cb | retn_as_cb)
- func_idx  in  N2  bin index of the function being left
- dump_start  in  1  single-cycle request to stream out all bins
- dump_ready  in  1  consumer accepts dump_data this cycle
- dump_valid  out  1  dump_data/dump_idx valid
- dump_idx  out  N2  bin index of dump_data
- dump_data  out  ACC_W  bin contents
- dump_done  out  1  one-cycle pulse after last bin accepted
- busy  out  1  high in CLEAR, DRAIN, DUMP
- acc_overflow  out  1  sticky: some bin addition overflowed ACC_W
- event_dropped  out  1  sticky: event arrived while busy

Behaviour:
- Reset (async, active-high): all outputs 0, pipeline valids 0, state=CLEAR, clear pointer=0. Reset mid-dump or mid-clear aborts that operation and restarts CLEAR.
- States:
  - CLEAR: write 0 to bin[ptr] each cycle, ptr 0..NB-1, then go to IDLE. Takes NB cycles; busy=1.
  - IDLE: accumulation active; busy=0 (unless DRAIN/DUMP).
  - DRAIN: entered on dump_start in IDLE. Waits until both pipeline stages are empty (at most 2 cycles), then goes to DUMP.
  - DUMP: streams bins as described below, then pulses dump_done and returns to IDLE.
  - dump_start outside IDLE is ignored.
- Accumulate pipeline (IDLE only):
  - S1: register {func_idx, zero-extended count} and issue RAM read of bin[func_idx].
  - S2: RAM data returns; sum = rdata + count_reg. Write sum to bin[idx] in the same cycle.
  - Event at cycle t is visible in the RAM from cycle t+2. Throughput is one event per cycle.
- Forwarding: if the S1 idx equals the S2 write idx in the cycle S1's read occurs, S1 uses the S2 sum instead of the stale RAM data.
  - Back-to-back events to the same bin must therefore accumulate exactly.
- Events while busy: discarded and event_dropped set (sticky until reset). event_valid with count=0 still performs a write (no-op value).
- Overflow: the addition is performed at ACC_W+1 bits. On carry-out, acc_overflow is set (sticky), and the bin wraps modulo 2**ACC_W.
- DUMP:
  - ptr starts at 0 with one-cycle RAM read latency; dump_valid rises once the first read returns.
  - dump_data/dump_idx hold stable while dump_valid & ~dump_ready.
  - On dump_valid & dump_ready: write 0 to bin[dump_idx] and advance. Bins are read ahead so that continuous dump_ready yields one bin per cycle.
  - After bin NB-1 is accepted: dump_valid=0, dump_done=1 for one cycle, state=IDLE.
- Events arriving in the same cycle as dump_start are accepted, and are included in the dump because of the DRAIN state.

Optional Feature:
- Macro: LEAP_ACC_SATURATE_EN.
- Defined: on carry-out, the bin is written as all ones (2**ACC_W-1) instead of wrapping, and acc_overflow is still set. A saturated bin stays saturated until it is cleared by dump or reset.
- Undefined: wrap-around behaviour as above.

Test Plan:
1. Reset deassert, then wait NB=256 cycles -> busy=1 for exactly 256 cycles. A dump then yields 256 beats all 0, with dump_done one cycle after the beat with idx 255.
2. Events (idx 3, count 10), then (idx 3, count 5) on consecutive cycles, then dump -> bin 3 = 15, all other bins 0. This proves forwarding.
3. Event (idx 7, count 0xFFFFFFFF) x3 with non-consecutive gaps, then dump -> bin 7 = 0x2_FFFFFFFD, acc_overflow=0.
4. Dump with dump_ready toggling 1,0,0,1 -> data/idx held while ready=0. Every bin is delivered exactly once in order, and a second dump returns all zeros.
5. event_valid pulsed during CLEAR and during DUMP -> the event has no effect on any bin and event_dropped=1.
6. With ACC_W=CW=32, bin 1 preloaded by events to 0xFFFFFFF0, then event count 0x20 -> without the macro: bin 1 = 0x10 and acc_overflow=1; with LEAP_ACC_SATURATE_EN: bin 1 = 0xFFFFFFFF and acc_overflow=1.
